// File: rtl/pixel_mixer.sv
// Final compositing stage: merges coin/character layers over a background into registered RGB 3-3-2.
// Define COIN_SCORE_EN to build the overlap flag, contact FSM, coin_hit pulse and BCD coin counter.
module pixel_mixer (
    input  logic        clk_i,
    input  logic        reset_ni,
    input  logic [10:0] hcount_i,
    input  logic [10:0] vcount_i,
    input  logic        blank_i,
    input  logic        r_coin_i,
    input  logic        g_coin_i,
    input  logic        b_coin_i,
    input  logic        char_px_i,
    output logic [2:0]  red_o,
    output logic [2:0]  green_o,
    output logic [1:0]  blue_o,
    output logic        coin_hit_o,
    output logic [3:0]  coin_tens_o,
    output logic [3:0]  coin_ones_o
);

    localparam logic [7:0]  COIN_RGB = 8'b111_111_00;
    localparam logic [7:0]  CHAR_RGB = 8'b111_000_00;
    localparam logic [7:0]  BG_RGB   = 8'b000_000_11;
    localparam logic [10:0] V_ACTIVE = 11'd480;

    logic       coin_px;
    logic [7:0] rgb_d, rgb_q;

    assign coin_px = r_coin_i | g_coin_i | b_coin_i;

    always_comb begin
        rgb_d = BG_RGB;
        if (blank_i) begin
            rgb_d = 8'h00;
        end else if (char_px_i) begin
            rgb_d = CHAR_RGB;
        end else if (coin_px) begin
            rgb_d = COIN_RGB;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            rgb_q <= 8'h00;
        end else begin
            rgb_q <= rgb_d;
        end
    end

    assign red_o   = rgb_q[7:5];
    assign green_o = rgb_q[4:2];
    assign blue_o  = rgb_q[1:0];

`ifdef COIN_SCORE_EN
    localparam logic StIdle    = 1'b0;
    localparam logic StContact = 1'b1;

    logic       frame_end;
    logic       flag_d, flag_q;
    logic       state_d, state_q;
    logic       hit_d, hit_q;
    logic [3:0] tens_d, tens_q;
    logic [3:0] ones_d, ones_q;

    assign frame_end = (vcount_i == V_ACTIVE) && (hcount_i == 11'd0);

    // The flag covers the frame just ending; the FSM reads its registered value at the boundary.
    always_comb begin
        flag_d  = flag_q | (coin_px & char_px_i & ~blank_i);
        state_d = state_q;
        hit_d   = 1'b0;
        if (frame_end) begin
            flag_d = 1'b0;
            case (state_q)
                StIdle: begin
                    if (flag_q) begin
                        state_d = StContact;
                        hit_d   = 1'b1;
                    end
                end
                default: begin
                    if (!flag_q) begin
                        state_d = StIdle;
                    end
                end
            endcase
        end
    end

    // Saturating two-digit BCD increment; a pulse at 99 leaves the count unchanged.
    always_comb begin
        tens_d = tens_q;
        ones_d = ones_q;
        if (hit_d && !(tens_q == 4'd9 && ones_q == 4'd9)) begin
            if (ones_q == 4'd9) begin
                ones_d = 4'd0;
                tens_d = tens_q + 4'd1;
            end else begin
                ones_d = ones_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            flag_q  <= 1'b0;
            state_q <= StIdle;
            hit_q   <= 1'b0;
            tens_q  <= 4'd0;
            ones_q  <= 4'd0;
        end else begin
            flag_q  <= flag_d;
            state_q <= state_d;
            hit_q   <= hit_d;
            tens_q  <= tens_d;
            ones_q  <= ones_d;
        end
    end

    assign coin_hit_o  = hit_q;
    assign coin_tens_o = tens_q;
    assign coin_ones_o = ones_q;
`else
    logic unused_timing;

    assign unused_timing = ^{hcount_i, vcount_i, V_ACTIVE};
    assign coin_hit_o    = 1'b0;
    assign coin_tens_o   = 4'd0;
    assign coin_ones_o   = 4'd0;
`endif

endmodule

// File: tb/tb_pixel_mixer.sv
// Directed bench for pixel_mixer: pixel priority, reset, contact episodes and BCD saturation.
// Scoring expectations follow whether COIN_SCORE_EN is defined for the build.
module tb_pixel_mixer;

`ifdef COIN_SCORE_EN
    localparam bit ScoreEn = 1'b1;
`else
    localparam bit ScoreEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic [10:0] hcount, vcount;
    logic        blank, r_coin, g_coin, b_coin, char_px;
    logic [2:0]  red, green;
    logic [1:0]  blue;
    logic        coin_hit;
    logic [3:0]  coin_tens, coin_ones;

    int n_cmp  = 0;
    int n_fail = 0;
    int cnt    = 0;

    always #5 clk = ~clk;

    pixel_mixer dut (
        .clk_i       (clk),
        .reset_ni    (reset_n),
        .hcount_i    (hcount),
        .vcount_i    (vcount),
        .blank_i     (blank),
        .r_coin_i    (r_coin),
        .g_coin_i    (g_coin),
        .b_coin_i    (b_coin),
        .char_px_i   (char_px),
        .red_o       (red),
        .green_o     (green),
        .blue_o      (blue),
        .coin_hit_o  (coin_hit),
        .coin_tens_o (coin_tens),
        .coin_ones_o (coin_ones)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [10:0] h, input logic [10:0] v, input logic bl,
                         input logic [2:0] coin, input logic ch);
        hcount  = h;
        vcount  = v;
        blank   = bl;
        r_coin  = coin[2];
        g_coin  = coin[1];
        b_coin  = coin[0];
        char_px = ch;
    endtask

    // Inputs change #1 after the edge, outputs are sampled there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_count(input string tag);
        check({tag, "_tens"}, {28'd0, coin_tens}, ScoreEn ? cnt / 10 : 0);
        check({tag, "_ones"}, {28'd0, coin_ones}, ScoreEn ? cnt % 10 : 0);
    endtask

    // One abbreviated frame: optional overlap pixel, plain active pixel, boundary, blank line.
    task automatic frame(input bit ov, input bit exp_hit);
        if (ov) begin
            drive(11'd50, 11'd20, 1'b0, 3'b010, 1'b1);
            step();
            check("ov_rgb", {24'd0, red, green, blue}, 32'hE0);
        end
        drive(11'd200, 11'd30, 1'b0, 3'b000, 1'b0);
        step();
        check("frame_nohit", {31'd0, coin_hit}, 0);
        drive(11'd0, 11'd480, 1'b1, 3'b000, 1'b0);
        step();
        if (exp_hit && cnt < 99) cnt++;
        check("frame_hit", {31'd0, coin_hit}, {31'd0, exp_hit & ScoreEn});
        check_count("frame");
        drive(11'd1, 11'd480, 1'b1, 3'b000, 1'b0);
        step();
        check("hit_width", {31'd0, coin_hit}, 0);
    endtask

    task automatic episode();
        frame(1'b0, 1'b0);
        frame(1'b1, 1'b1);
    endtask

    initial begin
        reset_n = 1'b0;
        drive(11'd0, 11'd0, 1'b0, 3'b100, 1'b0);
        #12;
        check("rst_rgb", {24'd0, red, green, blue}, 0);
        check("rst_hit", {31'd0, coin_hit}, 0);
        check_count("rst");
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        drive(11'd100, 11'd100, 1'b0, 3'b100, 1'b0);
        step();
        check("coin_r", {24'd0, red, green, blue}, 32'hFC);
        drive(11'd101, 11'd100, 1'b0, 3'b010, 1'b0);
        step();
        check("coin_g", {24'd0, red, green, blue}, 32'hFC);
        drive(11'd102, 11'd100, 1'b0, 3'b001, 1'b0);
        step();
        check("coin_b", {24'd0, red, green, blue}, 32'hFC);
        drive(11'd103, 11'd100, 1'b0, 3'b001, 1'b1);
        step();
        check("char_over_coin", {24'd0, red, green, blue}, 32'hE0);
        drive(11'd104, 11'd100, 1'b0, 3'b000, 1'b1);
        step();
        check("char_only", {24'd0, red, green, blue}, 32'hE0);
        drive(11'd105, 11'd100, 1'b0, 3'b000, 1'b0);
        step();
        check("background", {24'd0, red, green, blue}, 32'h03);
        drive(11'd700, 11'd100, 1'b1, 3'b111, 1'b1);
        step();
        check("blank", {24'd0, red, green, blue}, 0);

        // Frames 1-3 overlap, 4 clear, 5 overlap: pulses on frames 1 and 5.
        frame(1'b1, 1'b1);
        frame(1'b1, 1'b0);
        frame(1'b1, 1'b0);
        frame(1'b0, 1'b0);
        frame(1'b1, 1'b1);
        check_count("after5");

        for (int i = 0; i < 3; i++) episode();
        check_count("at05");

        // Mid-frame, mid-contact reset with the overlap flag set and a coloured pixel showing.
        drive(11'd60, 11'd40, 1'b0, 3'b100, 1'b1);
        step();
        drive(11'd61, 11'd40, 1'b0, 3'b100, 1'b0);
        step();
        check("pre_rst_rgb", {24'd0, red, green, blue}, 32'hFC);
        #2;
        reset_n = 1'b0;
        #1;
        cnt = 0;
        check("mid_rst_rgb", {24'd0, red, green, blue}, 0);
        check("mid_rst_hit", {31'd0, coin_hit}, 0);
        check_count("mid_rst");
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        // Flag was cleared and FSM is IDLE, so a clear frame is silent and the next overlap pulses.
        episode();
        check_count("post_rst");

        for (int i = 0; i < 8; i++) episode();
        check_count("at09");
        episode();
        check_count("at10");

        for (int i = 0; i < 89; i++) episode();
        check_count("at99");
        episode();
        check_count("sat99");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, required finish within budget");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pixel_mixer.md
# pixel_mixer

Final compositing stage of the VGA game display, directly downstream of the coin sprite renderer and the character renderer. It merges the 1-bit coin and character layer pixels over a constant background into registered 8-bit RGB (3-3-2) for the DAC pins. It also detects coin/character pixel overlap and turns each contact episode into a single collection event and a saturating two-digit BCD coin count.

## Interface
- COIN_RGB, 8'b111_111_00, colour driven when the coin layer wins (yellow).
- CHAR_RGB, 8'b111_000_00, colour driven when the character layer wins (red).
- BG_RGB, 8'b000_000_11, colour driven in active video when no layer is set.
- V_ACTIVE, 480, first non-visible line; used as the frame-boundary line.
- clk  in  1  pixel clock.
- reset  in  1  asynchronous, active-low reset.
- hcount  in  11  horizontal pixel counter from the timing generator.
- vcount  in  11  vertical line counter from the timing generator.
- blank  in  1  1 = outside active video.
- r_coin, g_coin, b_coin  in  1 each  coin layer bits; coin pixel = r_coin | g_coin | b_coin.
- char_px  in  1  character layer pixel, cycle-aligned with the coin layer bits.
- red  out  3  composited red.
- green  out  3  composited green.
- blue  out  2  composited blue.
- coin_hit  out  1  one-cycle pulse per new coin/character contact episode.
- coin_tens  out  4  BCD tens digit of the collected-coin count.
- coin_ones  out  4  BCD ones digit of the collected-coin count.

## Operation
- Priority: blank → 0; else char_px → CHAR_RGB; else coin pixel → COIN_RGB; else BG_RGB.
- {red, green, blue} is registered. Inputs are sampled on the rising edge of clk.
- The overlap flag sets on any cycle with coin pixel & char_px & !blank, and stays set until the frame boundary.
- Frame boundary: the single cycle with vcount == V_ACTIVE and hcount == 0.
- FSM states: IDLE and CONTACT. Transitions at the frame boundary only:
  - IDLE with flag set → CONTACT; pulse coin_hit; increment the count.
  - IDLE with flag clear → stay in IDLE.
  - CONTACT with flag set → stay in CONTACT; no pulse.
  - CONTACT with flag clear → IDLE.
- The flag clears at every frame boundary. A set on the boundary cycle itself cannot occur because blank is 1 there.
- Count arithmetic: BCD. Ones digit 9 → 0 with a carry into the tens digit. The count saturates at 99; at 99, coin_hit still pulses but the count holds.
- Reset (asserted at any time, including mid-frame or mid-contact):
  - red, green, blue, coin_hit = 0.
  - coin_tens, coin_ones = 0.
  - FSM = IDLE; flag cleared.
  - Normal operation resumes on the first rising edge after deassertion.

## Timing
- Pixel latency: 1 clk from the layer inputs to red, green and blue.
- blank is sampled in the same cycle as the layer bits, so the output is black exactly one cycle after blank rises.
- coin_hit is asserted in the cycle after the frame-boundary edge and lasts exactly 1 clk.
- coin_tens and coin_ones update in that same cycle.
- Minimum spacing between coin_hit pulses is 2 frames: enter CONTACT, spend one frame with no overlap, then one frame with overlap.
- No handshake. The downstream score logic samples coin_hit every cycle.

## Configuration
- COIN_SCORE_EN defined: the overlap flag, FSM, coin_hit and the BCD counter are built as described.
- COIN_SCORE_EN undefined: only the mixer is built. coin_hit, coin_tens and coin_ones are tied to 0, and pixel behaviour is identical.

## Test plan
- Reset low mid-frame with count at 05 → red, green, blue, coin_hit and the count are all 0 immediately; FSM in IDLE after release.
- blank=0, char_px=0, coin=1 → {red, green, blue} = 8'b111_111_00 one clk later. With char_px=1 as well → 8'b111_000_00. With blank=1 → 0.
- Overlap pixels in frames 1–3, none in frame 4, overlap again in frame 5 → coin_hit pulses only at the boundaries ending frames 1 and 5; count = 02.
- Preload the count to 09, then one contact episode → tens=1, ones=0.
- Count at 99, then a new contact episode → coin_hit pulses; count stays at 99.
- Build without COIN_SCORE_EN and apply overlap every frame → coin_hit stays 0 and count stays 00; pixel output matches the enabled build.
